// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (a - b - b_in), LSB first, start/busy/done.
// Define SERIAL_SUB_ADD_EN to add a mode input that turns the cell into an adder.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
`ifdef SERIAL_SUB_ADD_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             br;
    logic [CW-1:0]    count;
    logic             add_mode;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] next_res;

`ifdef SERIAL_SUB_ADD_EN
    logic mode_reg;
    assign add_mode = mode_reg;
`else
    assign add_mode = 1'b0;
`endif

    always_comb begin
        x       = a_reg[0];
        y       = b_reg[0];
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
        if (add_mode)
            br_next = (x & y) | (br & (x ^ y));
        // Result bits fill the a-reg from the top as its operand bits drain out.
        next_res = {d, a_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            br    <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
            mode_reg <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        br    <= b_in;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_ADD_EN
                        mode_reg <= mode;
`endif
                    end
                end
                SHIFT: begin
                    a_reg <= next_res;
                    b_reg <= {1'b0, b_reg[WIDTH-1:1]};
                    br    <= br_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        diff  <= next_res;
                        b_out <= br_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Randomised scoreboard bench for serial_sub (WIDTH=4).
// Builds with or without SERIAL_SUB_ADD_EN.
module tb_serial_sub;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         b_in  = 1'b0;
    logic         mode  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;

    serial_sub #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .b_in(b_in),
`ifdef SERIAL_SUB_ADD_EN
        .mode(mode),
`endif
        .busy(busy),
        .done(done),
        .diff(diff),
        .b_out(b_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   last   = -1000;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc++;

    function automatic exp_t model(input int av, input int bv,
                                   input int ci, input bit add);
        exp_t e;
        int   t;
        if (add) begin
            t    = av + bv + ci;
            e.bo = (t > MASK);
        end else begin
            t    = av - bv - ci;
            e.bo = (av < bv + ci);
        end
        e.d   = W'(t & MASK);
        e.cyc = 0;
        return e;
    endfunction

    // Called just after a rising edge; the start is sampled at the next edge.
    task automatic issue(input int av, input int bv, input int ci,
                         input bit add);
        exp_t e;
        a     = W'(av);
        b     = W'(bv);
        b_in  = ci[0];
        mode  = add;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        b_in  = 1'($urandom);
`ifndef SERIAL_SUB_ADD_EN
        add = 1'b0;
`endif
        if (cyc >= last + W + 1) begin
            e     = model(av, bv, ci, add);
            e.cyc = cyc + W;
            last  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < last + W && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        last  = -1000;
        exp_q.delete();
        checks++;
        if (diff !== '0 || b_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: diff=%0d b_out=%b busy=%b done=%b want all 0",
                     diff, b_out, busy, done);
        end
    endtask

    // Monitor: busy/done follow the acceptance model every cycle;
    // results are popped from the queue on done.
    always @(negedge clock) begin
        if (!reset) begin
            automatic bit want_busy = (cyc >= last) && (cyc < last + W);
            automatic bit want_done = (cyc == last + W);
            checks++;
            if (busy !== want_busy) begin
                errors++;
                $display("FAIL busy @%0d: got %b want %b", cyc, busy, want_busy);
            end
            checks++;
            if (done !== want_done) begin
                errors++;
                $display("FAIL done @%0d: got %b want %b", cyc, done, want_done);
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result @%0d: unexpected done", cyc);
                end else begin
                    automatic exp_t e = exp_q.pop_front();
                    if (diff !== e.d || b_out !== e.bo || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result @%0d: diff=%0d b_out=%b want diff=%0d b_out=%b at %0d",
                                 cyc, diff, b_out, e.d, e.bo, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_cycles(3);
        do_reset();
        idle_cycles(1);

        issue(7, 3, 0, 0);   wait_idle(); idle_cycles(1);
        issue(3, 4, 0, 0);   wait_idle(); idle_cycles(1);
        issue(9, 9, 1, 0);   wait_idle(); idle_cycles(1);
        issue(0, 15, 1, 0);  wait_idle(); idle_cycles(1);
        issue(6, 6, 0, 0);   wait_idle(); idle_cycles(1);

        // second start lands while busy and must be dropped
        issue(10, 5, 0, 0);
        idle_cycles(1);
        issue(1, 1, 0, 0);
        wait_idle(); idle_cycles(1);

        // start held into the done cycle
        issue(12, 2, 1, 0);
        wait_idle();
        issue(15, 0, 0, 0);
        wait_idle(); idle_cycles(1);

        // reset two cycles into an operation
        issue(8, 1, 0, 0);
        idle_cycles(1);
        do_reset();
        idle_cycles(6);
        issue(5, 2, 1, 0);   wait_idle(); idle_cycles(1);

`ifdef SERIAL_SUB_ADD_EN
        issue(10, 15, 0, 1); wait_idle(); idle_cycles(1);
        issue(3, 4, 1, 1);   wait_idle(); idle_cycles(1);
        issue(15, 15, 1, 1); wait_idle(); idle_cycles(1);
        issue(3, 4, 0, 0);   wait_idle(); idle_cycles(1);
`endif

        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, MASK), $urandom_range(0, MASK),
                  $urandom_range(0, 1), 1'($urandom));
            idle_cycles($urandom_range(0, 5));
        end
        wait_idle();
        idle_cycles(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
